pc_seq: RTL
===========

# pc_seq

Program-counter sequencer for the MSP430 core. A Moore/Mealy FSM that drives the 3-bit `MPC` select of the PC input mux, the memory read strobe and instruction-register load strobes. It sequences reset-vector load, opcode fetch, extension-word fetch, execution-time PC writes and interrupt-vector entry. It sits between the decoder/execute control and the PC register plus memory-address path.

## Interface
Parameters:
- `RESET_VEC`, 16'hFFFE, address of the reset vector word
- `IRQ_BASE`, 16'hFFE0, base address of the interrupt vector table (vector n at `IRQ_BASE + 2*n`)

Ports:
- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `mem_rdy` in 1: memory read data valid on MDB this cycle
- `dec_valid` in 1: decoder has a decoded instruction
- `dec_ext` in 2: extension words required (0–2; 3 treated as 2)
- `exec_done` in 1: execute phase complete this cycle
- `pc_wr` in 1: with `exec_done`, the instruction writes PC (value on CALC path)
- `irq_pend` in 1: maskable or non-maskable interrupt pending
- `irq_idx` in 4: vector index of the pending interrupt
- `MPC` out 3: PC mux select (0 HOLD, 1 INC, 2 CALC, 3 MDB_X2, 4 MDB)
- `mem_rd` out 1: memory read request
- `mab_vec` out 1: 1 = MAB driven from `vec_addr`, 0 = MAB driven from PC
- `vec_addr` out 16: vector address for the current vector read
- `ir_load` out 1: load opcode from MDB into IR
- `ext_load` out 1: load extension word from MDB
- `ext_idx` out 1: which extension word is loading (0 = source, 1 = destination)
- `busy` out 1: high in every state except EXEC

## Operation
- States: `RST_VEC`, `FETCH`, `DECODE`, `EXT`, `EXEC`, `IRQ_VEC`.
- **RST_VEC**
  - Outputs: `mem_rd`=1, `mab_vec`=1, `vec_addr`=`RESET_VEC`.
  - On `mem_rdy`: `MPC`=MDB (4), then → FETCH. Otherwise `MPC`=HOLD.
- **FETCH**
  - Outputs: `mem_rd`=1, `mab_vec`=0.
  - On `mem_rdy`: `ir_load`=1, `MPC`=INC, then → DECODE.
- **DECODE**
  - Outputs: `MPC`=HOLD.
  - On `dec_valid`: latch `min(dec_ext,2)` into the ext counter and clear `ext_idx`.
  - Next state: → EXT if the count is nonzero, else → EXEC.
- **EXT**
  - Outputs: `mem_rd`=1.
  - On `mem_rdy`: `ext_load`=1, `MPC`=INC, decrement the counter and set `ext_idx`.
  - Next state: → EXEC when the counter reaches 0.
- **EXEC**
  - Outputs: `mem_rd`=0, `MPC`=HOLD.
  - On `exec_done`: `MPC`=CALC if `pc_wr`, else HOLD.
  - Next state: → IRQ_VEC if `irq_pend`, else → FETCH.
- **IRQ_VEC**
  - Outputs: `mem_rd`=1, `mab_vec`=1, `vec_addr`=`IRQ_BASE + {irq_idx,1'b0}`, with `irq_idx` latched on entry.
  - On `mem_rdy`: `MPC`=MDB, then → FETCH.
- `MPC` values 3 and 5–7 are never driven.
- `MPC` is combinational from state and `mem_rdy`/`exec_done`/`pc_wr`, so the PC updates on the same edge that consumes the data.
- Without its qualifying input, every state outputs `MPC`=HOLD and stays in place.

## Timing
- Reset values while `rst`=1: state `RST_VEC`, `MPC`=0, `mem_rd`=0, `mab_vec`=1, `vec_addr`=`RESET_VEC`, `ir_load`=`ext_load`=`ext_idx`=0, `busy`=1.
- After `rst` deasserts: `mem_rd`=1 in the first cycle.
- Latency with zero-wait memory:
  - Reset-vector load: 1 cycle.
  - Fetch + decode: 2 cycles.
  - Each extension word: 1 cycle.
  - `exec_done` → next `mem_rd`: 1 cycle.
- Wait states: `mem_rd` stays high and `MPC`=HOLD for as many cycles as `mem_rdy`=0, with no limit.
- Interrupts are sampled only at the EXEC → next transition (instruction boundary).
- `pc_wr` together with `irq_pend`: CALC is applied first on that edge. The vector read follows, so the pushed PC is the branch target.
- `rst` asserted mid-fetch or mid-EXT: immediate asynchronous return to `RST_VEC`. Partial ext count and latched `irq_idx` are discarded.
- `dec_valid` is ignored outside DECODE. `exec_done` is ignored outside EXEC.

## Structure
- Shared package `pc_seq_pkg` holds:
  - MPC encoding constants (`MPC_HOLD`, `MPC_INC`, `MPC_CALC`, `MPC_MDB_X2`, `MPC_MDB`), shared with the PC mux.
  - The state enum.
  - Default `RESET_VEC` and `IRQ_BASE`.
- No sub-module. The ext counter and irq latch are inline registers.

## Test plan
- Reset release, `mem_rdy`=1, MDB=16'hC000 → `MPC`=4 for 1 cycle, then FETCH with `mab_vec`=0 and PC=16'hC000.
- Fetch with 2 wait states, `dec_ext`=2 → `MPC` sequence is HOLD, HOLD, INC, HOLD, INC, INC, and PC advances by 6. `ext_idx` is 0 then 1.
- `exec_done` with `pc_wr`=1, CALC=16'hC100 → `MPC`=2 and the next fetch is from 16'hC100.
- `exec_done` with `irq_pend`=1, `irq_idx`=5 → `vec_addr`=16'hFFEA and `MPC`=4 on `mem_rdy`.
- `dec_ext`=3 → exactly two ext loads.
- `rst` pulsed during EXT → outputs return to reset values asynchronously, and the sequence restarts at RST_VEC.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared PC-mux select codes, sequencer state enum and default vector addresses.
package pc_seq_pkg;
  localparam logic [2:0] MPC_HOLD   = 3'd0;
  localparam logic [2:0] MPC_INC    = 3'd1;
  localparam logic [2:0] MPC_CALC   = 3'd2;
  localparam logic [2:0] MPC_MDB_X2 = 3'd3;
  localparam logic [2:0] MPC_MDB    = 3'd4;
  localparam logic [15:0] RESET_VEC_DEF = 16'hFFFE;
  localparam logic [15:0] IRQ_BASE_DEF  = 16'hFFE0;
  typedef enum logic [2:0] {RST_VEC, FETCH, DECODE, EXT, EXEC, IRQ_VEC} state_t;
  function automatic logic [1:0] ext_clamp(input logic [1:0] n);
    return n[1] ? 2'd2 : n;
  endfunction
  function automatic logic [15:0] vec_of(input logic [15:0] base, input logic [3:0] idx);
    return base + {11'd0, idx, 1'b0};
  endfunction
endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if: control bundle between the PC sequencer and decoder/execute/PC/memory logic.
// master = sequencer side (consumes mem_rdy/dec_*/exec_*/irq_*, drives MPC and strobes);
// slave = surrounding core side.
interface pc_seq_if;
  logic        mem_rdy;
  logic        dec_valid;
  logic [1:0]  dec_ext;
  logic        exec_done;
  logic        pc_wr;
  logic        irq_pend;
  logic [3:0]  irq_idx;
  logic [2:0]  MPC;
  logic        mem_rd;
  logic        mab_vec;
  logic [15:0] vec_addr;
  logic        ir_load;
  logic        ext_load;
  logic        ext_idx;
  logic        busy;
  modport master(
    input  mem_rdy, dec_valid, dec_ext, exec_done, pc_wr, irq_pend, irq_idx,
    output MPC, mem_rd, mab_vec, vec_addr, ir_load, ext_load, ext_idx, busy
  );
  modport slave(
    output mem_rdy, dec_valid, dec_ext, exec_done, pc_wr, irq_pend, irq_idx,
    input  MPC, mem_rd, mab_vec, vec_addr, ir_load, ext_load, ext_idx, busy
  );
endinterface

// File: rtl/pc_seq.sv
// pc_seq: MSP430 program-counter sequencer (reset vector, fetch, ext words, exec PC write, irq vector).
// Ports: clk, rst (async, active high), bus (pc_seq_if.master).
// MPC and strobes are combinational so the PC updates on the edge that consumes MDB/CALC.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [15:0] IRQ_BASE  = IRQ_BASE_DEF
) (
  input logic       clk,
  input logic       rst,
  pc_seq_if.master  bus
);
  state_t     state, state_n;
  logic [1:0] ext_cnt;
  logic       ext_idx_r;
  logic [3:0] irq_idx_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_VEC;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      RST_VEC: state_n = bus.mem_rdy ? FETCH : RST_VEC;
      FETCH:   state_n = bus.mem_rdy ? DECODE : FETCH;
      DECODE:  state_n = !bus.dec_valid ? DECODE : (ext_clamp(bus.dec_ext) != 2'd0 ? EXT : EXEC);
      EXT:     state_n = (bus.mem_rdy && ext_cnt < 2'd2) ? EXEC : EXT;
      EXEC:    state_n = !bus.exec_done ? EXEC : (bus.irq_pend ? IRQ_VEC : FETCH);
      IRQ_VEC: state_n = bus.mem_rdy ? FETCH : IRQ_VEC;
      default: state_n = RST_VEC;
    endcase
  end
  // Ext counter and irq index latch; both discarded by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_cnt   <= 2'd0;
      ext_idx_r <= 1'b0;
      irq_idx_r <= 4'd0;
    end else begin
      if (state == DECODE && bus.dec_valid) begin
        ext_cnt   <= ext_clamp(bus.dec_ext);
        ext_idx_r <= 1'b0;
      end else if (state == EXT && bus.mem_rdy && ext_cnt != 2'd0) begin
        ext_cnt   <= ext_cnt - 2'd1;
        ext_idx_r <= 1'b1;
      end
      if (state == EXEC && bus.exec_done && bus.irq_pend) irq_idx_r <= bus.irq_idx;
    end
  end
  // rst gates the RST_VEC read strobe and MPC so reset shows mem_rd=0 / HOLD.
  always_comb begin
    bus.mem_rd   = !rst && (state inside {RST_VEC, FETCH, EXT, IRQ_VEC});
    bus.mab_vec  = state inside {RST_VEC, IRQ_VEC};
    bus.vec_addr = (state == IRQ_VEC) ? vec_of(IRQ_BASE, irq_idx_r) : RESET_VEC;
    bus.ir_load  = state == FETCH && bus.mem_rdy;
    bus.ext_load = state == EXT && bus.mem_rdy;
    bus.ext_idx  = ext_idx_r;
    bus.busy     = state != EXEC;
    bus.MPC      = rst ? MPC_HOLD :
                   ((state inside {RST_VEC, IRQ_VEC}) && bus.mem_rdy) ? MPC_MDB :
                   ((state inside {FETCH, EXT}) && bus.mem_rdy) ? MPC_INC :
                   (state == EXEC && bus.exec_done && bus.pc_wr) ? MPC_CALC : MPC_HOLD;
  end
endmodule
